apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001: Parameter DATA_WIDTH, default 32, sets the APB data bus width in bits.
REQ-002: Parameter ADDR_WIDTH, default 32, sets the APB address bus width in bits.
REQ-003: Parameter TIMEOUT_CYCLES, default 16, sets the maximum ACCESS cycles with PREADY low before abort (used only with APB_MASTER_TIMEOUT_EN).
REQ-004: One clock; reset is synchronous and active-low.
REQ-005: PCLK  input  1  system clock; all state updates on the rising edge.
REQ-006: PRESETn  input  1  synchronous active-low reset.
REQ-007: cmd_valid  input  1  a command is presented.
REQ-008: cmd_ready  output  1  the block accepts a command this cycle.
REQ-009: cmd_write  input  1  1 = write, 0 = read.
REQ-010: cmd_addr  input  ADDR_WIDTH  transfer address.
REQ-011: cmd_wdata  input  DATA_WIDTH  write data.
REQ-012: rsp_valid  output  1  one-cycle completion pulse.
REQ-013: rsp_rdata  output  DATA_WIDTH  captured read data.
REQ-014: rsp_err  output  1  slave error or timeout on the completed transfer.
REQ-015: rsp_timeout  output  1  the completed transfer aborted on timeout.
REQ-016: PADDR  output  ADDR_WIDTH  APB address.
REQ-017: PWRITE  output  1  APB direction.
REQ-018: PWDATA  output  DATA_WIDTH  APB write data.
REQ-019: PSELx  output  1  APB slave select.
REQ-020: PENABLE  output  1  APB enable.
REQ-021: PREADY  input  1  slave ready.
REQ-022: PRDATA  input  DATA_WIDTH  slave read data.
REQ-023: PSLVERR  input  1  slave error.

Function
REQ-024: The FSM SHALL have states IDLE, SETUP and ACCESS; all APB outputs and response outputs SHALL be registered.
REQ-025: cmd_ready SHALL be 1 only in IDLE; a handshake (cmd_valid & cmd_ready) SHALL register cmd_addr, cmd_write and cmd_wdata (write only; PWDATA is 0 for reads) and move to SETUP.
REQ-026: In SETUP, PSELx=1 and PENABLE=0 for exactly one cycle, followed unconditionally by ACCESS.
REQ-027: In ACCESS, PSELx=1 and PENABLE=1; the state SHALL hold while PREADY=0.
REQ-028: PADDR, PWRITE and PWDATA SHALL remain stable from SETUP through the last ACCESS cycle.
REQ-029: On an ACCESS cycle with PREADY=1, the next cycle SHALL drive rsp_valid=1, rsp_err=PSLVERR, rsp_timeout=0, and rsp_rdata=PRDATA for reads (0 for writes); state returns to IDLE with PSELx=PENABLE=0.
REQ-030: rsp_valid SHALL be high for exactly one cycle per accepted command; rsp_rdata/rsp_err SHALL hold their values until the next completion.
REQ-031: The minimum transfer SHALL be 3 cycles from handshake to rsp_valid; back-to-back commands SHALL be separated by at least one IDLE cycle, in which the bus is idle.
REQ-032: cmd_valid in SETUP or ACCESS SHALL be ignored.

Reset
REQ-033: While PRESETn=0 at a clock edge: state=IDLE; PSELx, PENABLE, PWRITE, rsp_valid, rsp_err and rsp_timeout = 0; PADDR, PWDATA and rsp_rdata = 0; timeout counter = 0.
REQ-034: Reset asserted mid-transfer SHALL abort the transfer with no rsp_valid pulse.

Configuration
REQ-035: Macro APB_MASTER_TIMEOUT_EN defined: a counter SHALL increment on each ACCESS cycle with PREADY=0; when it reaches TIMEOUT_CYCLES, the transfer SHALL abort with rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0, and return to IDLE. PREADY=1 on that same cycle SHALL take priority (normal completion).
REQ-036: Macro not defined: ACCESS SHALL wait indefinitely, and rsp_timeout SHALL be constant 0 (port retained).

Verification
REQ-037: Write 0x0000_0010 <- 0xDEAD_BEEF, PREADY=1 in the first ACCESS cycle -> SETUP then ACCESS, one cycle each; rsp_valid 3 cycles after handshake; rsp_err=0.
REQ-038: Read 0x0000_0020, PREADY low for 4 cycles, PRDATA=0x1234_5678 -> PENABLE high for 5 cycles; rsp_rdata=0x1234_5678.
REQ-039: Read completing with PSLVERR=1 -> rsp_err=1, rsp_timeout=0.
REQ-040: With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, PREADY held 0 -> abort after 16 stall cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-041: PRESETn low during ACCESS -> next cycle IDLE, PSELx=0, no rsp_valid; the following command completes normally.
REQ-042: cmd_valid held high for 3 commands -> exactly 3 handshakes and 3 rsp_valid pulses, with at least one idle bus cycle between transfers.

Source files
------------

// File: rtl/apb_master.sv
// APB master: turns single commands into APB SETUP/ACCESS transfers and returns a one-cycle response.
// Optional ACCESS stall timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PSELx,
    output logic                  PENABLE,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PSLVERR
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] paddr_next;
    logic                  pwrite_next;
    logic [DATA_WIDTH-1:0] pwdata_next;
    logic                  psel_next;
    logic                  penable_next;
    logic                  rsp_valid_next;
    logic [DATA_WIDTH-1:0] rsp_rdata_next;
    logic                  rsp_err_next;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] stall_cnt_next;
    logic             rsp_timeout_q;
    logic             rsp_timeout_next;

    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    assign cmd_ready = (state == IDLE);

    always_comb begin
        state_next     = state;
        paddr_next     = PADDR;
        pwrite_next    = PWRITE;
        pwdata_next    = PWDATA;
        psel_next      = PSELx;
        penable_next   = PENABLE;
        rsp_valid_next = 1'b0;
        rsp_rdata_next = rsp_rdata;
        rsp_err_next   = rsp_err;
`ifdef APB_MASTER_TIMEOUT_EN
        stall_cnt_next   = stall_cnt;
        rsp_timeout_next = rsp_timeout_q;
`endif
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_next   = SETUP;
                    paddr_next   = cmd_addr;
                    pwrite_next  = cmd_write;
                    pwdata_next  = cmd_write ? cmd_wdata : '0;
                    psel_next    = 1'b1;
                    penable_next = 1'b0;
                end
            end
            SETUP: begin
                state_next   = ACCESS;
                penable_next = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
                stall_cnt_next = '0;
`endif
            end
            ACCESS: begin
                // A ready slave always wins over a timeout reached in the same cycle.
                if (PREADY) begin
                    state_next     = IDLE;
                    psel_next      = 1'b0;
                    penable_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = PSLVERR;
                    rsp_rdata_next = PWRITE ? '0 : PRDATA;
`ifdef APB_MASTER_TIMEOUT_EN
                    rsp_timeout_next = 1'b0;
                    stall_cnt_next   = '0;
                end else if (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_next       = IDLE;
                    psel_next        = 1'b0;
                    penable_next     = 1'b0;
                    rsp_valid_next   = 1'b1;
                    rsp_err_next     = 1'b1;
                    rsp_rdata_next   = '0;
                    rsp_timeout_next = 1'b1;
                    stall_cnt_next   = '0;
                end else begin
                    stall_cnt_next = stall_cnt + 1'b1;
`endif
                end
            end
            default: begin
                state_next   = IDLE;
                psel_next    = 1'b0;
                penable_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state     <= IDLE;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            PSELx     <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            stall_cnt     <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            PADDR     <= paddr_next;
            PWRITE    <= pwrite_next;
            PWDATA    <= pwdata_next;
            PSELx     <= psel_next;
            PENABLE   <= penable_next;
            rsp_valid <= rsp_valid_next;
            rsp_rdata <= rsp_rdata_next;
            rsp_err   <= rsp_err_next;
`ifdef APB_MASTER_TIMEOUT_EN
            stall_cnt     <= stall_cnt_next;
            rsp_timeout_q <= rsp_timeout_next;
`endif
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed and random transfers against a slave model and transfer-level expectations.
// Timeout checks are compiled in when APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_master;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 16;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic [AW-1:0] PADDR;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic          PSELx;
    logic          PENABLE;
    logic          PREADY;
    logic [DW-1:0] PRDATA;
    logic          PSLVERR;

    int checks      = 0;
    int errors      = 0;
    int completions = 0;
    int pulses      = 0;

    apb_master #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .PADDR      (PADDR),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .PSELx      (PSELx),
        .PENABLE    (PENABLE),
        .PREADY     (PREADY),
        .PRDATA     (PRDATA),
        .PSLVERR    (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    always @(negedge PCLK) begin
        if (rsp_valid === 1'b1) pulses++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_psel"}, 64'(PSELx), 64'd0);
        checkOutput({tag, "_penable"}, 64'(PENABLE), 64'd0);
        checkOutput({tag, "_pwrite"}, 64'(PWRITE), 64'd0);
        checkOutput({tag, "_paddr"}, 64'(PADDR), 64'd0);
        checkOutput({tag, "_pwdata"}, 64'(PWDATA), 64'd0);
        checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        checkOutput({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
        checkOutput({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
        checkOutput({tag, "_rsp_timeout"}, 64'(rsp_timeout), 64'd0);
        checkOutput({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    endtask

    // One command: the slave model stalls 'waits' ACCESS cycles, then completes with rdata/err.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input int waits, input logic [31:0] rdata, input logic err,
                                 input logic keep);
        int          lat;
        int          setup_cnt;
        int          enable_cnt;
        logic        bus_ok;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        exp_wdata  = wr ? wdata : 32'd0;
        exp_rdata  = wr ? 32'd0 : rdata;
        cmd_valid  = 1'b1;
        cmd_write  = wr;
        cmd_addr   = addr;
        cmd_wdata  = wdata;
        checkOutput("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        @(posedge PCLK);
        @(negedge PCLK);
        completions++;
        lat        = 1;
        setup_cnt  = 0;
        enable_cnt = 0;
        bus_ok     = 1'b1;
        while (rsp_valid !== 1'b1 && lat < waits + 40) begin
            if (!keep) cmd_valid = 1'($urandom_range(0, 1));
            cmd_write = 1'($urandom_range(0, 1));
            cmd_addr  = $urandom;
            cmd_wdata = $urandom;
            if (PSELx !== 1'b1 || PADDR !== addr || PWRITE !== wr || PWDATA !== exp_wdata) bus_ok = 1'b0;
            if (PSELx === 1'b1 && PENABLE === 1'b0) setup_cnt++;
            if (PSELx === 1'b1 && PENABLE === 1'b1) begin
                enable_cnt++;
                PREADY = (enable_cnt == waits + 1);
            end else begin
                PREADY = 1'($urandom_range(0, 1));
            end
            PRDATA  = (PREADY && PENABLE === 1'b1) ? rdata : $urandom;
            PSLVERR = (PREADY && PENABLE === 1'b1) ? err : 1'($urandom_range(0, 1));
            @(negedge PCLK);
            lat++;
        end
        PREADY = 1'b0;
        if (!keep) cmd_valid = 1'b0;
        checkOutput("rsp_valid_seen", 64'(rsp_valid), 64'd1);
        checkOutput("latency", 64'(lat), 64'(waits + 3));
        checkOutput("setup_cycles", 64'(setup_cnt), 64'd1);
        checkOutput("enable_cycles", 64'(enable_cnt), 64'(waits + 1));
        checkOutput("bus_stable", 64'(bus_ok), 64'd1);
        checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
        checkOutput("rsp_err", 64'(rsp_err), 64'(err));
        checkOutput("rsp_timeout", 64'(rsp_timeout), 64'd0);
        checkOutput("idle_psel", 64'(PSELx), 64'd0);
        checkOutput("idle_penable", 64'(PENABLE), 64'd0);
        checkOutput("idle_cmd_ready", 64'(cmd_ready), 64'd1);
        if (!keep) begin
            @(negedge PCLK);
            checkOutput("rsp_pulse_one_cycle", 64'(rsp_valid), 64'd0);
            checkOutput("rsp_rdata_hold", 64'(rsp_rdata), 64'(exp_rdata));
            checkOutput("rsp_err_hold", 64'(rsp_err), 64'(err));
            checkOutput("bus_idle_after", 64'(PSELx), 64'd0);
        end
    endtask

    task automatic resetMidTransfer();
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_0040;
        cmd_wdata = 32'h0;
        PREADY    = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        repeat (3) @(negedge PCLK);
        checkOutput("mid_rst_in_access", 64'(PENABLE), 64'd1);
        PRESETn = 1'b0;
        @(negedge PCLK);
        checkResetState("mid_rst");
        PRESETn = 1'b1;
        PREADY  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            checkOutput("mid_rst_no_rsp", 64'(rsp_valid), 64'd0);
        end
        PREADY = 1'b0;
    endtask

`ifdef APB_MASTER_TIMEOUT_EN
    task automatic timeoutAbort();
        int lat;
        int enable_cnt;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_0080;
        cmd_wdata = 32'h0;
        PREADY    = 1'b0;
        PRDATA    = 32'hFFFF_FFFF;
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid  = 1'b0;
        completions++;
        lat        = 1;
        enable_cnt = 0;
        while (rsp_valid !== 1'b1 && lat < 60) begin
            if (PENABLE === 1'b1) enable_cnt++;
            @(negedge PCLK);
            lat++;
        end
        checkOutput("to_rsp_valid", 64'(rsp_valid), 64'd1);
        checkOutput("to_stall_cycles", 64'(enable_cnt), 64'(TO));
        checkOutput("to_rsp_err", 64'(rsp_err), 64'd1);
        checkOutput("to_rsp_timeout", 64'(rsp_timeout), 64'd1);
        checkOutput("to_rsp_rdata", 64'(rsp_rdata), 64'd0);
        checkOutput("to_psel", 64'(PSELx), 64'd0);
        @(negedge PCLK);
        checkOutput("to_pulse_one_cycle", 64'(rsp_valid), 64'd0);
    endtask
`endif

    initial begin
        PRESETn   = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        PREADY    = 1'b1;
        PRDATA    = $urandom;
        PSLVERR   = 1'b1;
        repeat (3) @(negedge PCLK);
        checkResetState("reset");
        cmd_valid = 1'b0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        PRESETn   = 1'b1;
        @(negedge PCLK);

        applyStimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0000_0020, 32'h0, 4, 32'h1234_5678, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0000_0030, 32'h0, 1, 32'hCAFE_F00D, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0000_0034, 32'h0, TO - 1, 32'hA5A5_5A5A, 1'b0, 1'b0);

        applyStimulus(1'b1, 32'h0000_0100, 32'h1111_1111, 0, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0000_0104, 32'h0, 2, 32'h2222_2222, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h0000_0108, 32'h3333_3333, 1, 32'h0, 1'b1, 1'b0);

        resetMidTransfer();
        applyStimulus(1'b0, 32'h0000_0044, 32'h0, 2, 32'h0BAD_C0DE, 1'b0, 1'b0);

`ifdef APB_MASTER_TIMEOUT_EN
        timeoutAbort();
        applyStimulus(1'b1, 32'h0000_0084, 32'h4444_4444, 0, 32'h0, 1'b0, 1'b0);
`endif

        for (int n = 0; n < 12; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom, int'($urandom_range(0, 6)),
                          $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        cmd_valid = 1'b0;
        repeat (2) @(negedge PCLK);
        #1;
        checkOutput("rsp_pulse_count", 64'(pulses), 64'(completions));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
